niossoc_button_evt_ctrl: RTL

//  Hardware service engine for the 4-bit push-button PIO slave in NiosSoc.

---
 rtl/niossoc_button_evt_ctrl_pkg.sv | 47 ++++
 rtl/niossoc_button_evt_ctrl_fifo.sv | 66 ++++++
 rtl/niossoc_button_evt_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/niossoc_button_evt_ctrl_pkg.sv
// Shared definitions for the NiosSoc push-button event engine: PIO register
// map, FSM state encoding and the registered bus-drive bundle.
package niossoc_button_evt_ctrl_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_CLR     = 3'd4,
        ST_PUSH    = 3'd5
    } evt_state_e;

    // Everything this block drives onto the PIO slave port; upper write
    // data bits are always zero so only the low nibble is stored.
    typedef struct packed {
        logic       cs;
        logic       wr_n;
        logic [1:0] addr;
        logic [3:0] wdata;
    } pio_bus_t;

    localparam pio_bus_t PIO_BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 2'd0, wdata: 4'd0};

    function automatic pio_bus_t pio_write(input logic [1:0] addr, input logic [3:0] data);
        pio_bus_t b;
        b.cs    = 1'b1;
        b.wr_n  = 1'b0;
        b.addr  = addr;
        b.wdata = data;
        return b;
    endfunction

    function automatic pio_bus_t pio_read(input logic [1:0] addr);
        pio_bus_t b;
        b.cs    = 1'b1;
        b.wr_n  = 1'b1;
        b.addr  = addr;
        b.wdata = 4'd0;
        return b;
    endfunction

endpackage

// File: rtl/niossoc_button_evt_ctrl_fifo.sv
// Small synchronous first-word-fall-through FIFO for button events.
// A write while full is ignored (full is judged before any same-cycle pop).
module niossoc_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage updates; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_wr    = wr_en & ~full;
        do_rd    = rd_en & ~empty;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset flushes the FIFO and zeroes storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/niossoc_button_evt_ctrl.sv
// Push-button PIO service engine: programs the irq mask, services each PIO
// irq by reading and clearing edge_capture, and queues the snapshot.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  INIT     | write mask_shadow to PIO irq_mask (waits for bus after reset)
//  IDLE     | watch for cfg_mask change (wins) or pio_irq
//  RD_ADDR  | read edge_capture, address phase
//  RD_CAP   | readdata valid: capture it; zero means spurious irq
//  CLR      | write 0 to edge_capture
//  PUSH     | enqueue capture, or drop and count if FIFO full
module niossoc_button_evt_ctrl
    import niossoc_button_evt_ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] RESET_MASK = 4'hF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [31:0] av_writedata,
    input  logic [31:0] av_readdata,
    input  logic        pio_irq,
    input  logic [3:0]  cfg_mask,
    output logic        evt_valid,
    output logic [3:0]  evt_data,
    input  logic        evt_ready,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);
    evt_state_e state_q, state_d;
    pio_bus_t   bus_q, bus_d;
    logic [3:0] mask_shadow_q, mask_shadow_d;
    logic [3:0] cap_q, cap_d;
    logic       overflow_q, overflow_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       fifo_wr, fifo_full, fifo_empty;
    logic       unused_rdata;

    assign unused_rdata  = ^av_readdata[31:4];

    assign av_chipselect = bus_q.cs;
    assign av_write_n    = bus_q.wr_n;
    assign av_address    = bus_q.addr;
    assign av_writedata  = {28'd0, bus_q.wdata};
    assign evt_valid     = ~fifo_empty;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;

    niossoc_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (cap_q),
        .rd_en   (evt_ready),
        .rd_data (evt_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state, bookkeeping and registered bus drive. Bus outputs are
    // computed from the next state so they are glitch-free and go idle on
    // reset; INIT therefore leaves only once its write is on the bus.
    always_comb begin
        state_d       = state_q;
        mask_shadow_d = mask_shadow_q;
        cap_d         = cap_q;
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_wr       = 1'b0;
        bus_d         = PIO_BUS_IDLE;

        case (state_q)
            ST_INIT: begin
                if (!bus_q.wr_n) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cfg_mask != mask_shadow_q) begin
                    mask_shadow_d = cfg_mask;
                    state_d       = ST_INIT;
                end else if (pio_irq) begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                cap_d   = av_readdata[3:0];
                state_d = (av_readdata[3:0] == 4'd0) ? ST_IDLE : ST_CLR;
            end
            ST_CLR: state_d = ST_PUSH;
            ST_PUSH: begin
                if (!fifo_full) begin
                    fifo_wr = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        case (state_d)
            ST_INIT:              bus_d = pio_write(PIO_ADDR_MASK, mask_shadow_d);
            ST_RD_ADDR, ST_RD_CAP: bus_d = pio_read(PIO_ADDR_EDGE);
            ST_CLR:               bus_d = pio_write(PIO_ADDR_EDGE, 4'd0);
            default:              bus_d = PIO_BUS_IDLE;
        endcase
    end

    // FSM and control registers; reset aborts any pass and idles the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT;
            bus_q         <= PIO_BUS_IDLE;
            mask_shadow_q <= RESET_MASK;
            cap_q         <= 4'd0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            bus_q         <= bus_d;
            mask_shadow_q <= mask_shadow_d;
            cap_q         <= cap_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule
